gppcu_wb_arbiter: RTL and testbench

Writeback-side counterpart of the GPPCU scoreboard. It collects completed results from two execution sources: ALU (src0) and LSU/MUL (src1). Each source has its own small FIFO, and the block retires at most one register write per cycle. The write goes to the register file and drives the scoreboard release (WRREG / WRREG_VALID), which clears the register's occupied bit.

---
 rtl/gppcu_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_gppcu_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gppcu_wb_arbiter.sv
// gppcu_wb_arbiter: two-source writeback collector. Each source lands in its
// own small FIFO; a round-robin arbiter retires one register write per cycle
// which doubles as the scoreboard release strobe.

module gppcu_wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          iACLK,
    input  logic          iRST,
    input  logic          iVALID,
    input  logic [W-1:0]  iDATA,
    output logic          oREADY,
    input  logic          iPOP,
    output logic [W-1:0]  oHEAD,
    output logic [AW:0]   oCOUNT
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push, pop;

    // Ready comes from the registered count only, so a pop in the same
    // cycle never makes room for a push; reset blocks acceptance outright.
    assign oREADY = !iRST && (cnt_q != FULL);
    assign push   = iVALID && oREADY;
    assign pop    = iPOP && (cnt_q != '0);
    assign oHEAD  = mem_q[rd_q];
    assign oCOUNT = cnt_q;

    // Pointer and occupancy next-state; simultaneous push/pop keeps count.
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: stale slots are never read past the count.
    always_ff @(posedge iACLK) begin
        if (push) mem_q[wr_q] <= iDATA;
    end
endmodule

module gppcu_wb_arbiter #(
    parameter int NUMREG = 32,
    parameter int DW     = 32,
    parameter int DEPTH  = 4,
    localparam int RBW   = $clog2(NUMREG),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           iACLK,
    input  logic           iRST,
    input  logic           iS0_VALID,
    input  logic [RBW-1:0] iS0_REG,
    input  logic [DW-1:0]  iS0_DATA,
    output logic           oS0_READY,
    input  logic           iS1_VALID,
    input  logic [RBW-1:0] iS1_REG,
    input  logic [DW-1:0]  iS1_DATA,
    output logic           oS1_READY,
    output logic [RBW-1:0] oWRREG,
    output logic [DW-1:0]  oWRDATA,
    output logic           oWRREG_VALID,
    output logic [AW:0]    oS0_COUNT,
    output logic [AW:0]    oS1_COUNT,
    output logic           oIDLE
);
    localparam int EW = RBW + DW;

    logic [EW-1:0]  head0, head1;
    logic           ne0, ne1, pop0, pop1;
    logic           rr_q, rr_d;
    logic           vld_q, vld_d;
    logic [RBW-1:0] reg_q, reg_d;
    logic [DW-1:0]  data_q, data_d;

    gppcu_wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo0 (
        .iACLK (iACLK), .iRST (iRST),
        .iVALID(iS0_VALID), .iDATA({iS0_REG, iS0_DATA}), .oREADY(oS0_READY),
        .iPOP  (pop0), .oHEAD(head0), .oCOUNT(oS0_COUNT)
    );

    gppcu_wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo1 (
        .iACLK (iACLK), .iRST (iRST),
        .iVALID(iS1_VALID), .iDATA({iS1_REG, iS1_DATA}), .oREADY(oS1_READY),
        .iPOP  (pop1), .oHEAD(head1), .oCOUNT(oS1_COUNT)
    );

    assign ne0 = (oS0_COUNT != '0);
    assign ne1 = (oS1_COUNT != '0);

    // Round-robin grant: rr only flips when both sources are contending.
    always_comb begin
        pop0   = 1'b0;
        pop1   = 1'b0;
        rr_d   = rr_q;
        vld_d  = 1'b0;
        reg_d  = reg_q;
        data_d = data_q;
        if (!iRST) begin
            if (ne0 && ne1) begin
                pop0 = !rr_q;
                pop1 = rr_q;
                rr_d = !rr_q;
            end else begin
                pop0 = ne0;
                pop1 = ne1;
            end
        end
        if (pop0) begin
            vld_d           = 1'b1;
            {reg_d, data_d} = head0;
        end else if (pop1) begin
            vld_d           = 1'b1;
            {reg_d, data_d} = head1;
        end
    end

    // Arbiter pointer and registered write port; data holds when idle.
    always_ff @(posedge iACLK) begin
        if (iRST) begin
            rr_q   <= 1'b0;
            vld_q  <= 1'b0;
            reg_q  <= '0;
            data_q <= '0;
        end else begin
            rr_q   <= rr_d;
            vld_q  <= vld_d;
            reg_q  <= reg_d;
            data_q <= data_d;
        end
    end

    assign oWRREG_VALID = vld_q;
    assign oWRREG       = reg_q;
    assign oWRDATA      = data_q;
    assign oIDLE        = !ne0 && !ne1 && !vld_q;
endmodule

// File: tb/tb_gppcu_wb_arbiter.sv
// Bench for gppcu_wb_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.

module tb_gppcu_wb_arbiter;
    localparam int NUMREG = 32;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int RBW    = 5;
    localparam int AW     = 2;

    typedef logic [RBW+DW-1:0] ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           v0 = 1'b0, v1 = 1'b0;
    logic [RBW-1:0] r0 = '0, r1 = '0;
    logic [DW-1:0]  d0 = '0, d1 = '0;
    logic           rdy0, rdy1, wvld, idle;
    logic [RBW-1:0] wreg;
    logic [DW-1:0]  wdata;
    logic [AW:0]    c0, c1;

    gppcu_wb_arbiter #(.NUMREG(NUMREG), .DW(DW), .DEPTH(DEPTH)) dut (
        .iACLK(clk), .iRST(rst),
        .iS0_VALID(v0), .iS0_REG(r0), .iS0_DATA(d0), .oS0_READY(rdy0),
        .iS1_VALID(v1), .iS1_REG(r1), .iS1_DATA(d1), .oS1_READY(rdy1),
        .oWRREG(wreg), .oWRDATA(wdata), .oWRREG_VALID(wvld),
        .oS0_COUNT(c0), .oS1_COUNT(c1), .oIDLE(idle)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: per-source queues, a favoured-source bit, and the
    // last retired entry. Updated on every rising edge.
    ent_t           q0[$], q1[$];
    bit             rr = 0;
    logic           m_vld = 0;
    logic [RBW-1:0] m_reg = '0;
    logic [DW-1:0]  m_data = '0;
    bit             acc0 = 0, acc1 = 0, chk_en = 0;
    int             cyc = 0;

    always @(posedge clk) begin
        ent_t e;
        int   pick;
        cyc++;
        if (rst) begin
            q0.delete(); q1.delete();
            rr = 0; m_vld = 0; m_reg = '0; m_data = '0;
            acc0 = 0; acc1 = 0; chk_en = 1;
        end else begin
            acc0 = v0 && (q0.size() < DEPTH);
            acc1 = v1 && (q1.size() < DEPTH);
            pick = -1;
            if (q0.size() != 0 && q1.size() != 0) begin
                pick = int'(rr);
                rr = !rr;
            end else if (q0.size() != 0) pick = 0;
            else if (q1.size() != 0) pick = 1;
            m_vld = (pick >= 0);
            if (pick == 0) begin e = q0.pop_front(); {m_reg, m_data} = e; end
            if (pick == 1) begin e = q1.pop_front(); {m_reg, m_data} = e; end
            if (acc0) q0.push_back({r0, d0});
            if (acc1) q1.push_back({r1, d1});
        end
    end

    // Per-cycle comparison and write log.
    int  log_reg[$];
    int  log_cyc[$];
    logic [DW-1:0] log_data[$];
    int  maxc0 = 0;
    bit  seen_full1 = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_valid", wvld, m_vld);
            chk("wr_reg", wreg, m_reg);
            chk("wr_data", wdata, m_data);
            chk("s0_count", c0, q0.size());
            chk("s1_count", c1, q1.size());
            chk("s0_ready", rdy0, !rst && q0.size() < DEPTH);
            chk("s1_ready", rdy1, !rst && q1.size() < DEPTH);
            chk("idle", idle, q0.size() == 0 && q1.size() == 0 && !m_vld);
            if (wvld === 1'b1) begin
                log_reg.push_back(int'(wreg));
                log_data.push_back(wdata);
                log_cyc.push_back(cyc);
            end
            if (int'(c0) > maxc0) maxc0 = int'(c0);
            if (c1 == 3'd4 && rdy1 == 1'b0) seen_full1 = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        log_reg.delete(); log_data.delete(); log_cyc.delete();
    endtask

    // Hold src0 valid until the model reports acceptance at an edge.
    task automatic push0(input int r, input logic [DW-1:0] d);
        bit ok = 0;
        v0 = 1'b1; r0 = RBW'(r); d0 = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = acc0;
        end
        if (!ok) chk("push0_timeout", 0, 1);
    endtask

    task automatic push1(input int r, input logic [DW-1:0] d);
        bit ok = 0;
        v1 = 1'b1; r1 = RBW'(r); d1 = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = acc1;
        end
        if (!ok) chk("push1_timeout", 0, 1);
    endtask

    task automatic chk_log(input string name, input int exp[$]);
        chk({name, "_len"}, log_reg.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_reg.size(); i++)
            chk(name, log_reg[i], exp[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int s0_seq[$], s1_seq[$], exp_s0[$], exp_s1[$], exp_w[$];

        // Reset held two cycles; ready reads 0 while in reset.
        step();
        chk("rst_ready0", rdy0, 0);
        chk("rst_ready1", rdy1, 0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_idle", idle, 1);
        chk("post_rst_ready0", rdy0, 1);
        chk("post_rst_ready1", rdy1, 1);
        chk("post_rst_cnt0", c0, 0);
        chk("post_rst_wvld", wvld, 0);
        chk("post_rst_wreg", wreg, 0);
        chk("post_rst_wdata", wdata, 0);

        // Single push: strobe appears only in the cycle after edge k+1.
        step();
        clear_log();
        v0 = 1'b1; r0 = 5'd5; d0 = 32'hDEADBEEF;
        step();
        v0 = 1'b0;
        #2 chk("single_k_vld", wvld, 0);
        step();
        #2 chk("single_vld", wvld, 1);
        chk("single_reg", wreg, 5);
        chk("single_data", wdata, 32'hDEADBEEF);
        step();
        #2 chk("single_after_vld", wvld, 0);
        chk("single_after_idle", idle, 1);
        chk("single_hold_reg", wreg, 5);
        chk("single_strobes", log_reg.size(), 1);

        // Contention: alternating grants starting with src0.
        step();
        clear_log();
        for (int i = 0; i < 3; i++) begin
            v0 = 1'b1; r0 = RBW'(1 + i); d0 = 32'hA000_0000 | (1 + i);
            v1 = 1'b1; r1 = RBW'(9 + i); d1 = 32'hB000_0000 | (9 + i);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        repeat (6) step();
        chk_log("contend", '{1, 9, 2, 10, 3, 11});
        if (log_cyc.size() == 6) chk("contend_back_to_back", log_cyc[5] - log_cyc[0], 5);
        else chk("contend_cycles", log_cyc.size(), 6);

        // Backpressure: src0 streams, src1 fills up and stalls, nothing lost.
        clear_log();
        fork
            begin
                for (int i = 0; i < 12; i++) push0(16 + i, 32'hA000_0000 | (16 + i));
                v0 = 1'b0;
            end
            begin
                step();
                for (int i = 0; i < 8; i++) push1(1 + i, 32'hB000_0000 | (1 + i));
                v1 = 1'b0;
            end
        join
        repeat (20) step();
        for (int i = 0; i < log_data.size(); i++) begin
            if (log_data[i][31:28] == 4'hA) s0_seq.push_back(log_reg[i]);
            else s1_seq.push_back(log_reg[i]);
        end
        for (int i = 0; i < 12; i++) exp_s0.push_back(16 + i);
        for (int i = 0; i < 8; i++) exp_s1.push_back(1 + i);
        chk("bp_s1_full_seen", seen_full1, 1);
        chk("bp_total", log_reg.size(), 20);
        chk("bp_s0_order", (s0_seq == exp_s0), 1);
        chk("bp_s1_order", (s1_seq == exp_s1), 1);

        // Wrap-around through src0: order exact, occupancy stays at one.
        clear_log();
        maxc0 = 0;
        for (int i = 0; i < 10; i++) push0(i, 32'hC000_0000 | i);
        v0 = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 10; i++) exp_w.push_back(i);
        chk_log("wrap", exp_w);
        chk("wrap_max_count", maxc0, 1);

        // Reset mid-stream drops queued entries and accepts nothing.
        for (int i = 0; i < 4; i++) begin
            v0 = 1'b1; r0 = RBW'(20 + i); d0 = 32'h1 + i;
            v1 = 1'b1; r1 = RBW'(24 + i); d1 = 32'h2 + i;
            step();
        end
        chk("mid_q0_nonempty", c0 != 0, 1);
        rst = 1'b1; v1 = 1'b0;
        v0 = 1'b1; r0 = 5'd30; d0 = 32'h30;
        #1 chk("mid_rst_ready0", rdy0, 0);
        step();
        clear_log();
        #1 chk("mid_rst_vld", wvld, 0);
        chk("mid_rst_cnt0", c0, 0);
        chk("mid_rst_cnt1", c1, 0);
        rst = 1'b0; v0 = 1'b0;
        repeat (3) step();
        chk("mid_no_strobes", log_reg.size(), 0);
        v0 = 1'b1; r0 = 5'd7; d0 = 32'h7777;
        step();
        v0 = 1'b0;
        step();
        #2 chk("mid_reg7_vld", wvld, 1);
        chk("mid_reg7_reg", wreg, 7);
        chk("mid_reg7_data", wdata, 32'h7777);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
